// File: rtl/intc_pkg.sv
// Shared types and constants for the interrupt sequencer.
// Holds the controller state encoding, default vector layout and vector address helper.
package intc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    ISR      = 2'd2,
    RETURN   = 2'd3
  } intc_state_t;

  localparam int unsigned INTC_VEC_BASE   = 32'h0000_00C0;
  localparam int unsigned INTC_VEC_STRIDE = 32'h0000_0010;

  // Full-width vector address; callers truncate to their program-memory width.
  function automatic logic [31:0] vec_addr(input logic [31:0] id,
                                           input logic [31:0] base   = INTC_VEC_BASE,
                                           input logic [31:0] stride = INTC_VEC_STRIDE);
    return base + id * stride;
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// One interrupt line: two-flop synchronizer followed by a rising-edge detector.
// A level held high yields a single-cycle rise pulse.
module irq_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic irq,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= irq;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt controller beside the program sequencer: latches, masks and prioritises requests,
// forces a one-cycle jump to the vector and a one-cycle jump back to the saved address on RETI.
module interrupt_sequencer
  import intc_pkg::*;
#(
  parameter int unsigned          NUM_IRQ    = 4,
  parameter int unsigned          PM_ADDR_W  = 8,
  parameter logic [PM_ADDR_W-1:0] VEC_BASE   = PM_ADDR_W'(INTC_VEC_BASE),
  parameter logic [PM_ADDR_W-1:0] VEC_STRIDE = PM_ADDR_W'(INTC_VEC_STRIDE),
  localparam int unsigned         ID_W       = $clog2(NUM_IRQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_IRQ-1:0]   irq,
  input  logic                 mask_wr,
  input  logic [NUM_IRQ-1:0]   mask_data,
  input  logic                 ie_wr,
  input  logic                 ie_data,
  input  logic [PM_ADDR_W-1:0] pm_next,
  input  logic                 reti,
  output logic                 int_jmp,
  output logic [PM_ADDR_W-1:0] int_addr,
  output logic                 in_isr,
  output logic [ID_W-1:0]      active_id,
  output logic [NUM_IRQ-1:0]   pending
);

  intc_state_t          state;
  intc_state_t          state_nxt;
  logic [NUM_IRQ-1:0]   rise;
  logic [NUM_IRQ-1:0]   pend_q;
  logic [NUM_IRQ-1:0]   mask_q;
  logic [NUM_IRQ-1:0]   req;
  logic [NUM_IRQ-1:0]   clr;
  logic                 ie_q;
  logic                 eligible;
  logic [ID_W-1:0]      aid_q;
  logic [ID_W-1:0]      winner;
  logic [PM_ADDR_W-1:0] ret_q;
  logic [PM_ADDR_W-1:0] vec_q;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_edge_sync u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .irq     (irq[g]),
      .rise    (rise[g])
    );
  end

  // Lowest enabled pending index wins.
  always_comb begin
    req      = pend_q & mask_q;
    eligible = ie_q & (|req);
    winner   = '0;
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (req[i-1]) winner = ID_W'(i - 1);
    end
  end

  always_comb begin
    clr = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      clr[i] = (state == DISPATCH) && (aid_q == ID_W'(i));
    end
  end

  assign vec_q = PM_ADDR_W'(vec_addr(32'(aid_q), 32'(VEC_BASE), 32'(VEC_STRIDE)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      pend_q <= '0;
      mask_q <= '0;
      ie_q   <= 1'b0;
      aid_q  <= '0;
      ret_q  <= '0;
    end else begin
      state  <= state_nxt;
      // A new rise on the line being dispatched survives its own clear.
      pend_q <= (pend_q & ~clr) | rise;
      if (mask_wr) mask_q <= mask_data;
      if (ie_wr) ie_q <= ie_data;
      if ((state == IDLE) && eligible) aid_q <= winner;
      if (state == DISPATCH) ret_q <= pm_next;
    end
  end

  always_comb begin
    state_nxt = state;
    int_jmp   = 1'b0;
    int_addr  = '0;
    in_isr    = 1'b0;
    unique case (state)
      IDLE: begin
        if (eligible) state_nxt = DISPATCH;
      end
      DISPATCH: begin
        int_jmp   = 1'b1;
        int_addr  = vec_q;
        in_isr    = 1'b1;
        state_nxt = ISR;
      end
      ISR: begin
        in_isr = 1'b1;
        if (reti) state_nxt = RETURN;
      end
      RETURN: begin
        int_jmp   = 1'b1;
        int_addr  = ret_q;
        in_isr    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign active_id = aid_q;
  assign pending   = pend_q;

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Interrupt controller that sequences the program sequencer.
- Latches edge-triggered interrupt requests, masks them and selects one by fixed priority.
- Forces a one-cycle jump to a vector address, saves the return address, and forces the jump back on RETI.
- Sits beside the program sequencer. Its `int_jmp`/`int_addr` override the sequencer's `pm_addr` mux with priority above `jmp`/`jmp_nz`.

Parameters:
- NUM_IRQ, 4, number of interrupt lines (2..8).
- PM_ADDR_W, 8, program-memory address width.
- VEC_BASE, 8'hC0, vector address of irq 0.
- VEC_STRIDE, 8'h10, address spacing between consecutive vectors.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- irq  in  NUM_IRQ  raw interrupt lines, rising-edge sensitive, asynchronous to clk.
- mask_wr  in  1  load `mask` register from `mask_data`.
- mask_data  in  NUM_IRQ  per-line enable (1 = enabled).
- ie_wr  in  1  load global interrupt enable from `ie_data`.
- ie_data  in  1  global enable value.
- pm_next  in  PM_ADDR_W  sequencer's next `pm_addr` candidate before interrupt override.
- reti  in  1  decoded return-from-interrupt instruction, one cycle.
- int_jmp  out  1  force `pm_addr` = `int_addr` this cycle.
- int_addr  out  PM_ADDR_W  forced address; 0 when `int_jmp` = 0.
- in_isr  out  1  handler is executing.
- active_id  out  $clog2(NUM_IRQ)  id of the serviced interrupt.
- pending  out  NUM_IRQ  latched, unserviced requests.

Behaviour:
- Reset (async, `reset_n` = 0) forces:
  - `int_jmp` = 0, `int_addr` = 0, `in_isr` = 0, `active_id` = 0, `pending` = 0;
  - `mask` = 0, `ie` = 0, `ret_addr` = 0;
  - synchronizers = 0, FSM = IDLE.
- Reset applies mid-ISR too: no return jump is issued afterwards.
- Per line, input path:
  - two-flop synchronizer, then a previous-value flop;
  - `rise` = `sync2` & ~`prev`.
- Latency: `irq` first sampled high at edge n gives `pending[i]` = 1 after edge n+2.
- Levels held high produce only one request.
- Pending rules:
  - `pending[i]` is set on `rise[i]` regardless of `mask`/`ie`.
  - It is cleared only when line i is dispatched.
  - If set and clear coincide, set wins: a second request is retained.
- `eligible` = `ie` & |(`pending` & `mask`).
- Winner = lowest eligible index.
- `mask_wr`/`ie_wr` take effect from the next cycle. Both may be written in any state.
- FSM (Moore; `int_jmp` is never combinational from inputs):
  - IDLE: if `eligible`, register winner into `active_id`, then go to DISPATCH.
  - DISPATCH (1 cycle):
    - `int_jmp` = 1, `int_addr` = (VEC_BASE + `active_id`*VEC_STRIDE) mod 2^PM_ADDR_W;
    - `ret_addr` <= `pm_next`;
    - clear `pending[active_id]`;
    - go to ISR.
  - ISR: `in_isr` = 1. On `reti`, go to RETURN; otherwise stay.
  - RETURN (1 cycle): `int_jmp` = 1, `int_addr` = `ret_addr`; go to IDLE.
- `in_isr` = 1 in DISPATCH, ISR and RETURN.
- No nesting: requests arriving during ISR only latch into `pending`.
- After RETURN, the IDLE cycle re-evaluates `eligible`. There is always at least one IDLE cycle between consecutive dispatches, so at least one non-handler instruction is fetched between handlers.
- `active_id` holds until the next dispatch.
- `reti` outside ISR is ignored. `reti` in the DISPATCH cycle is ignored.
- Clearing `ie` during ISR does not cancel the return.
- If `mask` drops for the winner between IDLE and DISPATCH, the dispatch still completes; the winner is frozen.
- `ret_addr` captures `pm_next` as-is. A jump candidate from the sequencer is therefore preserved as the return target.
- Vector arithmetic is PM_ADDR_W bits and wraps silently.

Decomposition:
- Package `intc_pkg`:
  - enum `intc_state_t` {IDLE, DISPATCH, ISR, RETURN};
  - default VEC_BASE/VEC_STRIDE constants;
  - function `vec_addr(id)`.
- Sub-module `irq_edge_sync`: one line's 2-flop synchronizer plus rise detect, instantiated NUM_IRQ times.
- Priority encoder, pending, FSM and `ret_addr` live in the top module.

Test Plan:
- Reset release, `irq` idle, `ie` = 0 → all outputs 0 for 20 cycles. Then pulse `irq[2]` → `pending` = 4'b0100, no `int_jmp`.
- `ie` = 1, `mask` = 4'hF, `pm_next` = 8'h23, raise `irq[1]` at edge n:
  - `pending[1]` after edge n+2;
  - `int_jmp` = 1 and `int_addr` = 8'hD0 in DISPATCH, exactly one cycle;
  - `pending[1]` clears;
  - `reti` → `int_jmp` = 1, `int_addr` = 8'h23, then IDLE.
- `irq[3]` and `irq[0]` rise in the same cycle → irq 0 is serviced first (`int_addr` = 8'hC0). After RETURN, one IDLE cycle, then DISPATCH to 8'hF0.
- During ISR, pulse `irq[1]` twice → no dispatch while `in_isr` = 1; `pending[1]` stays 1. One dispatch follows the `reti`.
- `mask` = 4'b1110, `irq[0]` pulse → pending but no dispatch. Write `mask` = 4'hF → dispatch to 8'hC0 within 2 cycles.
- Assert `reset_n` = 0 mid-ISR (asynchronously, between edges) → outputs 0 immediately. `reti` after release produces no `int_jmp`.
